// File: rtl/add_tree_pipe.sv
// add_tree_pipe: pipelined unsigned reduction of N_IN W-bit operands, one register per pairwise level.
// Define ADD_TREE_PIPE_ACC_EN to add an accumulator stage that sums tree results over in_last-terminated packets.
module add_tree_pipe #(
    parameter int N_IN  = 64,
    parameter int W     = 5,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN*W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_last
);
    localparam int LEVELS = $clog2(N_IN);
    localparam int OW     = W + LEVELS;

    // Handshake: a beat moves on an edge where the producer's valid and the
    // consumer's ready are both high; valid is never withdrawn and payload is
    // held constant while valid && !ready.
    logic          tail_drain;
    logic [OW-1:0] tree_sum;
    logic          tree_valid;
    logic          tree_last;

    for (genvar k = 1; k <= LEVELS; k++) begin : lvl
        localparam int NK = N_IN >> k;
        localparam int WK = W + k;

        logic [2*NK*(WK-1)-1:0] src;
        logic                   src_valid;
        logic                   src_last;
        logic [NK*WK-1:0]       sum_d;
        logic [NK*WK-1:0]       data_q;
        logic                   valid_q;
        logic                   last_q;
        logic                   drain;
        logic                   load;

        if (k == 1) begin : g_src
            assign src       = in_data;
            assign src_valid = in_valid;
            assign src_last  = in_last;
        end else begin : g_src
            assign src       = lvl[k-1].data_q;
            assign src_valid = lvl[k-1].valid_q;
            assign src_last  = lvl[k-1].last_q;
        end

        // A level empties when its successor takes the entry, so bubbles collapse.
        if (k == LEVELS) begin : g_drain
            assign drain = tail_drain;
        end else begin : g_drain
            assign drain = lvl[k+1].load;
        end

        assign load = src_valid && (!valid_q || drain);

        for (genvar j = 0; j < NK; j++) begin : node
            assign sum_d[j*WK +: WK] = {1'b0, src[(2*j)*(WK-1) +: WK-1]}
                                     + {1'b0, src[(2*j+1)*(WK-1) +: WK-1]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (load) begin
                data_q  <= sum_d;
                valid_q <= 1'b1;
                last_q  <= src_last;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign tree_sum   = lvl[LEVELS].data_q;
    assign tree_valid = lvl[LEVELS].valid_q;
    assign tree_last  = lvl[LEVELS].last_q;

    // Held low in reset so nothing is offered an accept while state is clearing.
    assign in_ready = rst_n && (!lvl[1].valid_q || lvl[1].drain);

`ifdef ADD_TREE_PIPE_ACC_EN
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] sum_q;
    logic             valid_q;
    logic             last_q;

    assign acc_next   = acc_q + ACC_W'(tree_sum);
    // The accumulator waits while a finished packet total is still unaccepted.
    assign tail_drain = tree_valid && (!valid_q || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
            if (tail_drain) begin
                if (tree_last) begin
                    sum_q   <= acc_next;
                    valid_q <= 1'b1;
                    last_q  <= 1'b1;
                    acc_q   <= '0;
                end else begin
                    acc_q   <= acc_next;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_last  = last_q;
`else
    assign tail_drain = tree_valid && out_ready;
    assign out_valid  = tree_valid;
    assign out_sum    = ACC_W'(tree_sum);
    assign out_last   = tree_last;
`endif

endmodule

// File: tb/tb_add_tree_pipe.sv
// Self-checking bench for add_tree_pipe: table vectors, random streaming, stall capacity and mid-flight reset.
// With ADD_TREE_PIPE_ACC_EN defined, beats are marked last so each forms its own packet, plus packet tests.
module tb_add_tree_pipe;
    localparam int N_IN   = 64;
    localparam int W      = 5;
    localparam int ACC_W  = 16;
    localparam int LEVELS = 6;
`ifdef ADD_TREE_PIPE_ACC_EN
    localparam int LAT    = LEVELS + 1;
    localparam bit ACC    = 1'b1;
`else
    localparam int LAT    = LEVELS;
    localparam bit ACC    = 1'b0;
`endif

    typedef logic [N_IN*W-1:0] data_t;
    typedef struct {
        data_t            data;
        logic             last;
        logic [ACC_W-1:0] exp_sum;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    data_t            in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_last;
    logic [ACC_W-1:0] out_sum;

    add_tree_pipe #(.N_IN(N_IN), .W(W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int out_cnt = 0;
    int last_out_cyc = 0;
    int stall_cnt = 0;
    logic [ACC_W:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- scoreboard: pop on every output handshake ----
    always @(negedge clk) begin : monitor
        logic [ACC_W:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(e[ACC_W-1:0]));
                check("out_last", 32'(out_last), 32'(e[ACC_W]));
            end
            out_cnt++;
            last_out_cyc = cyc;
        end
    end

    // ---- model and drivers ----
    function automatic logic [ACC_W-1:0] ref_sum(input data_t d);
        int s = 0;
        for (int i = 0; i < N_IN; i++) s += int'(d[i*W +: W]);
        return ACC_W'(s);
    endfunction

    function automatic data_t fill(input int v);
        data_t r;
        for (int i = 0; i < N_IN; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    function automatic data_t rand_data();
        data_t r;
        for (int i = 0; i < N_IN; i++) r[i*W +: W] = W'($urandom_range(0, 31));
        return r;
    endfunction

    // Offer one beat; called and returning at posedge+1.
    task automatic send_beat(input data_t d, input logic l, input logic [ACC_W-1:0] e,
                             input bit push, output int acc_cyc);
        acc_cyc = -1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 100 && acc_cyc < 0; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) exp_q.push_back({l, e});
                acc_cyc = cyc;
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc_cyc < 0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_outputs(input int n, input int budget);
        for (int t = 0; t < budget && out_cnt < n; t++) @(posedge clk);
        if (out_cnt < n) check("out_timeout", 32'(out_cnt), 32'(n));
        #1;
    endtask

    vec_t vecs[7];

    initial begin : main
        int acc_c;
        int first_c;
        int base;
        int accepted;
        logic lst;
        data_t d;

        // ---- vector table ----
        vecs[0] = '{fill(31), 1'b1, 16'd1984};
        vecs[1] = '{fill(0),  1'b0, 16'd0};
        d = '0;
        for (int i = 0; i < N_IN; i += 2) d[i*W +: W] = 5'd31;
        vecs[2] = '{d, 1'b1, 16'd992};
        for (int i = 0; i < N_IN; i++) d[i*W +: W] = W'(i % 32);
        vecs[3] = '{d, 1'b0, 16'd992};
        d = '0;
        d[(N_IN-1)*W +: W] = 5'd31;
        vecs[4] = '{d, 1'b1, 16'd31};
        d = '0;
        d[0 +: W] = 5'd1;
        vecs[5] = '{d, 1'b0, 16'd1};
        vecs[6] = '{fill(1), 1'b1, 16'd64};

        // ---- reset state ----
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---- table vectors, one at a time, latency check ----
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            lst = ACC ? 1'b1 : vecs[v].last;
            base = out_cnt;
            send_beat(vecs[v].data, lst, vecs[v].exp_sum, 1'b1, acc_c);
            wait_outputs(base + 1, 30);
            check("latency", 32'(last_out_cyc - acc_c), 32'(LAT));
        end

        // ---- 20 random beats back to back ----
        base = out_cnt;
        stall_cnt = 0;
        first_c = 0;
        for (int i = 0; i < 20; i++) begin
            d = rand_data();
            lst = ACC ? 1'b1 : 1'($urandom_range(0, 1));
            send_beat(d, lst, ref_sum(d), 1'b1, acc_c);
            if (i == 0) first_c = acc_c;
        end
        wait_outputs(base + 20, 60);
        check("stream_no_stall", 32'(stall_cnt), 32'd0);
        check("stream_rate", 32'(last_out_cyc - first_c), 32'(LAT + 19));

        // ---- stall: capacity and hold ----
        out_ready = 1'b0;
        base = out_cnt;
        accepted = 0;
        in_valid = 1'b1;
        in_data  = rand_data();
        in_last  = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({1'b1, ref_sum(in_data)});
                accepted++;
            end
            @(posedge clk);
            #1;
            in_data = rand_data();
        end
        in_valid = 1'b0;
        check("stall_capacity", 32'(accepted), 32'(LAT));
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 0 || t == 9) begin
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_out_sum", 32'(out_sum), 32'(exp_q[0][ACC_W-1:0]));
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pipe_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        d = fill(2);
        send_beat(d, 1'b1, 16'd128, 1'b1, acc_c);
        wait_outputs(base + LAT + 1, 40);
        check("stall_drained", 32'(out_cnt - base), 32'(LAT + 1));

        // ---- reset with beats in flight ----
        base = out_cnt;
        for (int i = 0; i < 3; i++) send_beat(fill(7), 1'b1, 16'd448, 1'b0, acc_c);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_stale", 32'(out_cnt - base), 32'd0);
        send_beat(fill(31), 1'b1, 16'd1984, 1'b1, acc_c);
        wait_outputs(base + 1, 30);
        check("post_midrst_latency", 32'(last_out_cyc - acc_c), 32'(LAT));

`ifdef ADD_TREE_PIPE_ACC_EN
        // ---- packet accumulation ----
        base = out_cnt;
        send_beat(fill(31), 1'b0, 16'd0, 1'b0, acc_c);
        send_beat(fill(31), 1'b0, 16'd0, 1'b0, acc_c);
        send_beat(fill(31), 1'b1, 16'd5952, 1'b1, acc_c);
        wait_outputs(base + 1, 30);
        check("acc_latency", 32'(last_out_cyc - acc_c), 32'(LAT));
        repeat (5) @(posedge clk);
        #1;
        check("acc_single_out", 32'(out_cnt - base), 32'd1);
        // 34 * 1984 = 67456 wraps to 1920 in 16 bits
        base = out_cnt;
        for (int i = 0; i < 34; i++)
            send_beat(fill(31), 1'(i == 33), 16'd1920, 1'(i == 33), acc_c);
        wait_outputs(base + 1, 30);
        base = out_cnt;
        send_beat(fill(1), 1'b1, 16'd64, 1'b1, acc_c);
        wait_outputs(base + 1, 30);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/add_tree_pipe.md
# add_tree_pipe

Parametrised, pipelined unsigned reduction tree. Each accepted beat carries N_IN operands of W bits, and the block returns their full-precision sum. Pairwise levels are built for any power-of-two N_IN, with one register per level and valid/ready flow control at both ends. It sits between the operand-packing front end and the wide-result assembly of the parallel adder datapath, and can optionally accumulate over multi-beat packets.

## Interface
Parameters:
- N_IN, 64: operand count; power of two, at least 2.
- W, 5: operand width in bits.
- ACC_W, 16: out_sum width; must be at least W + log2(N_IN).

Derived values:
- LEVELS = log2(N_IN).
- OW = W + LEVELS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_ready  output  1  block accepts a beat when in_valid && in_ready.
- in_data  input  N_IN*W  operand i at bits [i*W +: W], unsigned.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  1  out_sum/out_last valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_sum  output  ACC_W  result, zero-extended from OW.
- out_last  output  1  packet-end flag travelling with the result.

## Operation
- Level k (k = 1..LEVELS) holds N_IN/2^k partial sums of W+k bits.
  - Node j of level k = node 2j + node 2j+1 of level k-1, carry kept, no truncation.
  - Level 0 is in_data.
- Each level register has a valid bit, plus a last bit travelling with it.
- Level k loads when its input is valid and the level is empty or draining this cycle.
- A level drains when its successor loads it; the final level drains on out_valid && out_ready.
- Bubbles collapse, so an empty slot is filled even while a later level is stalled.
- in_ready = level-1 empty or level-1 draining. It is combinational from out_ready only through this drain chain.
- out_valid, out_sum and out_last come directly from the final register; there is no combinational path from in_* to out_*.
- Data and last registers hold their value while stalled and never change while valid && !ready.
- Reset, including assertion mid-operation: every valid bit clears and every data/last register clears immediately.
  - out_valid=0, out_sum=0, out_last=0, in_ready=0 while rst_n is low.
  - After release, in_ready=1 on the first cycle.
  - In-flight beats are discarded, not flushed.

## Timing
- Latency: LEVELS cycles from the accepting edge to out_valid high with no stall (6 for N_IN=64).
- Throughput: one beat per cycle while out_ready is held high.
- Capacity: LEVELS beats in flight. With out_ready low, in_ready falls after LEVELS beats have been accepted.
- Back-to-back: an accept and a drain in the same cycle on a full pipe are both legal. in_ready stays 1 when out_ready=1.

## Configuration
- Macro: ADD_TREE_PIPE_ACC_EN.
- Without the macro:
  - Every beat produces one result: out_sum = zero-extended tree sum.
  - out_last = that beat's in_last.
- With the macro:
  - An accumulator stage is added after the tree, so latency becomes LEVELS+1 and capacity LEVELS+1.
  - acc <= acc + tree_sum on every tree output, modulo 2^ACC_W (wrap-around, no saturation).
  - Only beats with in_last=1 produce an output: out_sum = acc including that beat, out_last=1. The accumulator then clears to 0 in the same edge.
  - Non-last beats are absorbed without asserting out_valid.
  - The accumulator stalls with the output: it does not add while its pending result is unaccepted.
  - Reset clears acc to 0.

## Test plan
- Default build, N_IN=64, W=5: one beat, all operands 31, out_ready=1 -> out_sum=1984 (0x7C0), out_valid exactly 6 cycles after accept, out_last equal to in_last.
- 20 consecutive random beats, out_ready=1 -> 20 results in order, matching the reference sum, one per cycle, in_ready never low.
- out_ready=0, keep offering beats -> exactly 6 beats accepted, then in_ready=0. out_sum stays stable for 10 cycles. Raise out_ready -> all 6 results drain in order.
- Assert rst_n low for 1 cycle with 3 beats in flight -> out_valid=0 and out_sum=0 asynchronously; no stale result appears afterwards.
- ADD_TREE_PIPE_ACC_EN, ACC_W=16: 3 beats of all 31, last on the third -> single output 5952 with out_last=1, 7 cycles after the third accept.
- ADD_TREE_PIPE_ACC_EN, ACC_W=11: 2 beats of all 31, last on the second -> out_sum = 3968 mod 2048 = 1920; the next packet starts from 0.
